// File: rtl/tof_collector_pkg.sv
// Shared widths, sample-word layout and payload struct for the ToF sample collector.
// Define TOF_SAMPLE_TIMESTAMP_EN to prepend a 16-bit capture timestamp to every sample.
package tof_collector_pkg;

  localparam int unsigned TOF_DATA_W = 22;
  localparam int unsigned DIST_W     = 16;
  localparam int unsigned SIDX_W     = 6;
  localparam int unsigned SRC_W      = 3;
  localparam int unsigned TS_W       = 16;

  // Field offsets inside the sample word (LSB positions)
  localparam int unsigned DIST_LSB = 0;
  localparam int unsigned SIDX_LSB = DIST_LSB + DIST_W;
  localparam int unsigned SRC_LSB  = SIDX_LSB + SIDX_W;
  localparam int unsigned TS_LSB   = SRC_LSB + SRC_W;

`ifdef TOF_SAMPLE_TIMESTAMP_EN
  localparam int unsigned SAMPLE_W = TS_LSB + TS_W;
`else
  localparam int unsigned SAMPLE_W = TS_LSB;
`endif

  typedef struct packed {
`ifdef TOF_SAMPLE_TIMESTAMP_EN
    logic [TS_W-1:0]   ts;
`endif
    logic [SRC_W-1:0]  src;
    logic [SIDX_W-1:0] sensor_idx;
    logic [DIST_W-1:0] distance;
  } sample_t;

endpackage

// File: rtl/tof_sample_fifo.sv
// Synchronous FIFO with a registered head word; a push into an empty (or draining-to-empty)
// FIFO is visible on o_data/o_valid one cycle later.
module tof_sample_fifo #(
  parameter int unsigned WIDTH = 25,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_valid,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic [WIDTH-1:0] r_data;
  logic             r_valid;

  logic [AW-1:0]    w_rd_nxt;
  logic [LW-1:0]    w_level_popped;
  logic [LW-1:0]    w_level_nxt;
  logic             w_pop;
  logic             w_push;
  logic             w_bypass;

  assign o_full  = (r_level == LW'(DEPTH));
  assign o_empty = !r_valid;
  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_level = r_level;

  // A simultaneous pop frees the slot for a push on a full FIFO
  always_comb begin
    w_pop          = i_pop && r_valid;
    w_push         = i_push && (!o_full || w_pop);
    w_rd_nxt       = w_pop ? r_rd_ptr + AW'(1) : r_rd_ptr;
    w_level_popped = r_level - LW'(w_pop);
    w_level_nxt    = w_level_popped + LW'(w_push);
    w_bypass       = w_push && (w_level_popped == '0);
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_valid  <= 1'b0;
      r_data   <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      r_rd_ptr <= w_rd_nxt;
      r_level  <= w_level_nxt;
      r_valid  <= (w_level_nxt != '0);
      // Head word: take the incoming sample when it becomes the head, else the next stored entry
      if (w_bypass) begin
        r_data <= i_data;
      end else if (w_pop && (w_level_popped != '0)) begin
        r_data <= r_mem[w_rd_nxt];
      end
    end
  end

endmodule

// File: rtl/tof_sample_collector.sv
// Round-robin scanner over the upstream ToF ready flags; captures the selected sample into a FIFO.
// Define TOF_SAMPLE_TIMESTAMP_EN to add a free-running 16-bit capture timestamp to m_data.
module tof_sample_collector
  import tof_collector_pkg::*;
#(
  parameter int unsigned NB_OF_SENSORS = 8,
  parameter int unsigned FIFO_DEPTH    = 16,
  parameter int unsigned DROP_CNT_W    = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [7:0]                    tof_ready,
  input  logic [TOF_DATA_W-1:0]         tof_data,
  output logic [SRC_W-1:0]              tof_index,
  output logic [SAMPLE_W-1:0]           m_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [DROP_CNT_W-1:0]         drop_count
);

  logic [SRC_W-1:0]      r_index;
  logic [DROP_CNT_W-1:0] r_drop;
  logic [SRC_W-1:0]      w_index_nxt;
  logic [7:0]            w_mask;
  logic                  w_found;
  int unsigned           w_cand;
  logic                  w_hit;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_space_ok;
  logic                  w_push;
  sample_t               w_sample;

`ifdef TOF_SAMPLE_TIMESTAMP_EN
  logic [TS_W-1:0] r_ts;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_ts <= '0;
    else       r_ts <= r_ts + TS_W'(1);
  end
`endif

  assign tof_index  = r_index;
  assign drop_count = r_drop;

  always_comb begin
    w_hit      = tof_ready[r_index];
    w_space_ok = !w_full || (!w_empty && m_ready);
    w_push     = w_hit && w_space_ok;
  end

  always_comb begin
    w_sample            = '0;
    w_sample.src        = r_index;
    w_sample.sensor_idx = tof_data[TOF_DATA_W-1:DIST_W];
    w_sample.distance   = tof_data[DIST_W-1:0];
`ifdef TOF_SAMPLE_TIMESTAMP_EN
    w_sample.ts         = r_ts;
`endif
  end

  // Next index: first pending flag after the current one, wrapping at NB_OF_SENSORS
  always_comb begin
    w_mask      = '0;
    w_index_nxt = r_index;
    w_found     = 1'b0;
    w_cand      = '0;
    for (int i = 0; i < 8; i++) begin
      if ((i < int'(NB_OF_SENSORS)) && (i != int'(r_index))) w_mask[i] = tof_ready[i];
    end
    for (int unsigned k = 1; k < NB_OF_SENSORS; k++) begin
      w_cand = 32'(r_index) + k;
      if (w_cand >= NB_OF_SENSORS) w_cand = w_cand - NB_OF_SENSORS;
      if (!w_found && w_mask[SRC_W'(w_cand)]) begin
        w_index_nxt = SRC_W'(w_cand);
        w_found     = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_index <= '0;
      r_drop  <= '0;
    end else begin
      r_index <= w_index_nxt;
      if (w_hit && !w_space_ok && (r_drop != '1)) r_drop <= r_drop + DROP_CNT_W'(1);
    end
  end

  tof_sample_fifo #(
    .WIDTH (SAMPLE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_data  (w_sample),
    .i_pop   (m_ready),
    .o_data  (m_data),
    .o_valid (m_valid),
    .o_level (fifo_level),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

endmodule
